// File: rtl/timepulse_generator_pkg.sv
// Shared timing types for the time-pulse generator: run states, counter limits
// and the registered output bundle with its decode from SP/TP state.
package timepulse_generator_pkg;

    localparam int NUM_TP = 12;
    localparam int NUM_SP = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } tp_state_e;

    typedef struct packed {
        logic [NUM_TP-1:0] t_n;
        logic              rt_n;
        logic              wt_n;
        logic              ct_n;
        logic              tt_n;
        logic              mstopped;
        logic              mcyc_end;
    } tp_out_t;

    // Outputs for a given state; evaluated on next-state so they land registered.
    function automatic tp_out_t decode(tp_state_e st, logic [3:0] tp, logic [1:0] sp);
        tp_out_t o;
        o          = '1;
        o.mstopped = 1'b0;
        o.mcyc_end = 1'b0;
        if (st == HALT) begin
            o.mstopped = 1'b1;
        end else begin
            o.t_n      = ~(12'b1 << (tp - 4'd1));
            o.rt_n     = (sp != 2'd0);
            o.wt_n     = (sp != 2'd1);
            o.ct_n     = (sp != 2'd2);
            o.tt_n     = (sp != 2'd3);
            o.mcyc_end = (tp == 4'd12) && (sp == 2'd3);
        end
        return o;
    endfunction

endpackage

// File: rtl/timepulse_generator_edge_rise.sv
// Rising-edge detector: one-cycle pulse when level goes 0 -> 1.
module edge_rise (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= 1'b0;
        else       prev_q <= level_i;
    end

    assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/timepulse_generator.sv
// Memory-cycle time-pulse generator: 12 time pulses x 4 subphases, with halt,
// single-step and restart (GOJAM) control. All outputs are registered.
module timepulse_generator
    import timepulse_generator_pkg::*;
(
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        STOP,
    input  logic        MSTP,
    input  logic        GOJAM,
    output logic [11:0] T_n,
    output logic        RT_n,
    output logic        WT_n,
    output logic        CT_n,
    output logic        TT_n,
    output logic        T10_n,
    output logic        MSTOPPED,
    output logic        MCYC_END
);

    tp_state_e state_q, state_d;
    logic [3:0] tp_q, tp_d;
    logic [1:0] sp_q, sp_d;
    tp_out_t    out_q;
    logic       mstp_rise;

    edge_rise u_mstp_edge (
        .clk_i   (SIM_CLK),
        .rst_i   (SIM_RST),
        .level_i (MSTP),
        .pulse_o (mstp_rise)
    );

    always_comb begin
        state_d = state_q;
        tp_d    = tp_q;
        sp_d    = sp_q;
        case (state_q)
            RUN, STEP: begin
                sp_d = sp_q + 2'd1;
                if (sp_q == 2'(NUM_SP - 1)) begin
                    if (tp_q == 4'(NUM_TP)) begin
                        tp_d    = 4'd1;
                        state_d = STOP ? HALT : RUN;
                    end else begin
                        tp_d = tp_q + 4'd1;
                    end
                end
            end
            HALT: begin
                sp_d = 2'd0;
                tp_d = 4'd1;
                if (!STOP)          state_d = RUN;
                else if (mstp_rise) state_d = STEP;
            end
            default: begin
                state_d = RUN;
                tp_d    = 4'd1;
                sp_d    = 2'd0;
            end
        endcase
        // Restart wins over halt and step requests in the same cycle.
        if (GOJAM) begin
            state_d = RUN;
            tp_d    = 4'd1;
            sp_d    = 2'd0;
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q <= RUN;
            tp_q    <= 4'd1;
            sp_q    <= 2'd0;
            out_q   <= decode(RUN, 4'd1, 2'd0);
        end else begin
            state_q <= state_d;
            tp_q    <= tp_d;
            sp_q    <= sp_d;
            out_q   <= decode(state_d, tp_d, sp_d);
        end
    end

    assign T_n      = out_q.t_n;
    assign RT_n     = out_q.rt_n;
    assign WT_n     = out_q.wt_n;
    assign CT_n     = out_q.ct_n;
    assign TT_n     = out_q.tt_n;
    assign T10_n    = out_q.t_n[9];
    assign MSTOPPED = out_q.mstopped;
    assign MCYC_END = out_q.mcyc_end;

endmodule

// File: tb/tb_timepulse_generator.sv
// Directed vector bench for timepulse_generator: a vector table of inputs and
// expected registered outputs, plus a hand-written step-then-release sequence.
module tb_timepulse_generator;

    logic        clk = 1'b0;
    logic        rst, stop, mstp, gojam;
    logic [11:0] T_n;
    logic        RT_n, WT_n, CT_n, TT_n, T10_n, MSTOPPED, MCYC_END;

    int checks = 0;
    int errors = 0;

    timepulse_generator dut (
        .SIM_CLK  (clk),
        .SIM_RST  (rst),
        .STOP     (stop),
        .MSTP     (mstp),
        .GOJAM    (gojam),
        .T_n      (T_n),
        .RT_n     (RT_n),
        .WT_n     (WT_n),
        .CT_n     (CT_n),
        .TT_n     (TT_n),
        .T10_n    (T10_n),
        .MSTOPPED (MSTOPPED),
        .MCYC_END (MCYC_END)
    );

    always #5 clk = ~clk;

    // {T_n, RT_n, WT_n, CT_n, TT_n, T10_n, MSTOPPED, MCYC_END}
    typedef struct {
        string       name;
        logic        rst;
        logic        stop;
        logic        mstp;
        logic        gojam;
        logic [18:0] exp;
    } vec_t;

    vec_t vq[$];

    localparam logic [18:0] EXP_HALT = {12'hFFF, 4'hF, 1'b1, 1'b1, 1'b0};

    // Expected outputs for cycle m (0..47) of a running memory cycle.
    function automatic logic [18:0] exp_run(int m);
        logic [11:0] t;
        int          sp;
        t  = ~(12'b1 << (m / 4));
        sp = m % 4;
        return {t, sp != 0, sp != 1, sp != 2, sp != 3, t[9], 1'b0, m == 47};
    endfunction

    function automatic void add(string nm, logic r, logic s, logic mp, logic g, logic [18:0] e);
        vec_t v;
        v.name = nm; v.rst = r; v.stop = s; v.mstp = mp; v.gojam = g; v.exp = e;
        vq.push_back(v);
    endfunction

    function automatic void add_cycle(string nm, logic s, logic mp, int from, int to);
        for (int m = from; m <= to; m++) add(nm, 1'b0, s, mp, 1'b0, exp_run(m));
    endfunction

    task automatic apply(input vec_t v);
        logic [18:0] act;
        rst = v.rst; stop = v.stop; mstp = v.mstp; gojam = v.gojam;
        @(posedge clk);
        #1;
        act = {T_n, RT_n, WT_n, CT_n, TT_n, T10_n, MSTOPPED, MCYC_END};
        checks++;
        assert (act == v.exp)
        else begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", v.name, $time, act, v.exp);
        end
        checks++;
        assert ($onehot0(~T_n) && $onehot0(~{RT_n, WT_n, CT_n, TT_n}) &&
                (MSTOPPED || ($onehot(~T_n) && $onehot(~{RT_n, WT_n, CT_n, TT_n}))))
        else begin
            errors++;
            $display("FAIL onehot at %0t: T_n=%h strobes=%b expected one-hot", $time,
                     T_n, {RT_n, WT_n, CT_n, TT_n});
        end
    endtask

    task automatic hand(string nm, logic s, logic mp, logic [18:0] e);
        vec_t v;
        v.name = nm; v.rst = 1'b0; v.stop = s; v.mstp = mp; v.gojam = 1'b0; v.exp = e;
        apply(v);
    endtask

    initial begin
        rst = 1'b1; stop = 1'b0; mstp = 1'b0; gojam = 1'b0;

        // Reset, then two free-running memory cycles.
        add("reset", 1'b1, 1'b0, 1'b0, 1'b0, exp_run(0));
        add("reset", 1'b1, 1'b0, 1'b0, 1'b0, exp_run(0));
        for (int c = 1; c < 96; c++) add("run96", 1'b0, 1'b0, 1'b0, 1'b0, exp_run(c % 48));

        // STOP raised at T05: cycle completes, then halt; release resumes at T01.
        add_cycle("stop_t05", 1'b0, 1'b0, 0, 15);
        add_cycle("stop_t05", 1'b1, 1'b0, 16, 47);
        for (int i = 0; i < 4; i++) add("halt", 1'b0, 1'b1, 1'b0, 1'b0, EXP_HALT);
        add("halt_exit", 1'b0, 1'b0, 1'b0, 1'b0, exp_run(0));
        add_cycle("rehalt", 1'b1, 1'b0, 1, 47);
        add("halt", 1'b0, 1'b1, 1'b0, 1'b0, EXP_HALT);

        // Three single steps, 60 cycles apart; MSTP held high into HALT must not re-step.
        for (int k = 0; k < 3; k++) begin
            add("step_start", 1'b0, 1'b1, 1'b1, 1'b0, exp_run(0));
            add_cycle("step", 1'b1, 1'b1, 1, 47);
            add("step_halt", 1'b0, 1'b1, 1'b1, 1'b0, EXP_HALT);
            for (int i = 0; i < 11; i++) add("step_idle", 1'b0, 1'b1, 1'b0, 1'b0, EXP_HALT);
        end

        // GOJAM at T07 subphase 2 truncates the cycle with no MCYC_END.
        add("resume", 1'b0, 1'b0, 1'b0, 1'b0, exp_run(0));
        add_cycle("pre_gojam", 1'b0, 1'b0, 1, 26);
        add("gojam_run", 1'b0, 1'b0, 1'b0, 1'b1, exp_run(0));
        add_cycle("post_gojam", 1'b1, 1'b0, 1, 47);
        add("halt", 1'b0, 1'b1, 1'b0, 1'b0, EXP_HALT);

        // GOJAM in HALT with STOP=1: one full cycle then halt again.
        add("gojam_halt", 1'b0, 1'b1, 1'b0, 1'b1, exp_run(0));
        add_cycle("gojam_cycle", 1'b1, 1'b0, 1, 47);
        add("halt", 1'b0, 1'b1, 1'b0, 1'b0, EXP_HALT);
        add("halt", 1'b0, 1'b1, 1'b0, 1'b0, EXP_HALT);

        // Reset during STEP at T09 with MSTP held high.
        add("step_start", 1'b0, 1'b1, 1'b1, 1'b0, exp_run(0));
        add_cycle("step_t09", 1'b1, 1'b1, 1, 32);
        add("rst_step", 1'b1, 1'b1, 1'b1, 1'b0, exp_run(0));
        add("rst_step", 1'b1, 1'b1, 1'b1, 1'b0, exp_run(0));
        add_cycle("post_rst", 1'b1, 1'b1, 1, 47);
        for (int i = 0; i < 5; i++) add("no_spur_step", 1'b0, 1'b1, 1'b1, 1'b0, EXP_HALT);
        add("halt", 1'b0, 1'b1, 1'b0, 1'b0, EXP_HALT);

        // STOP pulsed mid-T12 but low at the sampling point: no halt.
        add("resume", 1'b0, 1'b0, 1'b0, 1'b0, exp_run(0));
        add_cycle("stop_glitch", 1'b0, 1'b0, 1, 46);
        add("stop_glitch", 1'b0, 1'b1, 1'b0, 1'b0, exp_run(47));
        add("no_halt", 1'b0, 1'b0, 1'b0, 1'b0, exp_run(0));
        add_cycle("rehalt", 1'b1, 1'b0, 1, 47);
        add("halt", 1'b0, 1'b1, 1'b0, 1'b0, EXP_HALT);

        foreach (vq[i]) apply(vq[i]);

        // Step, then drop STOP mid-step: the step ends in RUN rather than HALT.
        hand("hs_step_start", 1'b1, 1'b1, exp_run(0));
        for (int m = 1; m < 48; m++) hand("hs_step", 1'b0, 1'b0, exp_run(m));
        hand("hs_step_to_run", 1'b0, 1'b0, exp_run(0));
        for (int m = 1; m < 8; m++) hand("hs_running", 1'b0, 1'b0, exp_run(m));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timepulse_generator.md
TIMEPULSE_GENERATOR -- requirements
Module: timepulse_generator

Interface
REQ-001 SHALL have port SIM_CLK, input, 1, the only clock; all state changes on its rising edge.
REQ-002 SHALL have port SIM_RST, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port STOP, input, 1, halt request, sampled only at the end of T12.
REQ-004 SHALL have port MSTP, input, 1, monitor single-step request, level; the block detects its rising edge internally.
REQ-005 SHALL have port GOJAM, input, 1, restart request; forces a new memory cycle to begin at T01.
REQ-006 SHALL have port T_n, output, 12, one-hot active-low time pulses; bit k-1 = Tk_n.
REQ-007 SHALL have port RT_n, output, 1, read strobe, active-low, asserted in subphase 0.
REQ-008 SHALL have port WT_n, output, 1, write strobe, active-low, asserted in subphase 1.
REQ-009 SHALL have port CT_n, output, 1, clear strobe, active-low, asserted in subphase 2.
REQ-010 SHALL have port TT_n, output, 1, transfer strobe, active-low, asserted in subphase 3.
REQ-011 SHALL have port T10_n, output, 1, active-low; a copy of T_n[9].
REQ-012 SHALL have port MSTOPPED, output, 1, high while the block is halted.
REQ-013 SHALL have port MCYC_END, output, 1, one-cycle pulse on the last subphase of T12.

Function
REQ-014 SHALL keep a 2-bit subphase counter SP (0..3) and a 4-bit time-pulse counter TP (1..12).
- SP increments every cycle while running.
- TP increments when SP=3; it wraps from 12 to 1.
REQ-015 SHALL register all outputs: each output reflects the current SP/TP state with zero combinational input-to-output paths.
REQ-016 SHALL have exactly one T_n bit low while running; RT_n, WT_n, CT_n and TT_n SHALL be mutually exclusive.
REQ-017 SHALL implement three states: RUN, HALT, STEP.
REQ-018 In RUN at TP=12, SP=3: if STOP=1, the next state SHALL be HALT; otherwise TP SHALL wrap to 1.
REQ-019 In HALT:
- T_n SHALL be all ones.
- All four strobes SHALL be high.
- MSTOPPED SHALL be 1.
- SP and TP SHALL be held at 0 and 1.
REQ-020 In HALT with STOP=0, the block SHALL enter RUN, with T01 subphase 0 on the next cycle.
REQ-021 In HALT with STOP=1 and a rising edge on MSTP, the block SHALL enter STEP, run exactly one 48-cycle memory cycle, then return to HALT.
REQ-022 STOP deasserted during STEP SHALL cause RUN instead of HALT at the end of the step.
REQ-023 GOJAM=1 in any state SHALL force TP=1, SP=0 and state RUN on the next cycle, overriding STOP and MSTP in that cycle.
- A memory cycle of 48 cycles then follows.
- STOP is next sampled at its end.
REQ-024 MCYC_END SHALL pulse for every completed T12 subphase 3, including in STEP, and SHALL NOT pulse on a GOJAM-truncated cycle.

Reset
REQ-025 On SIM_RST=1 the block SHALL be in state RUN with TP=1 and SP=0.
- Outputs in the first cycle after reset: T_n = 12'hFFE, RT_n=0, WT_n=CT_n=TT_n=1, MSTOPPED=0, MCYC_END=0.
- The MSTP edge detector SHALL be cleared, so MSTP held high through reset produces no step.
REQ-026 SIM_RST SHALL dominate GOJAM, STOP and MSTP.

Structure
REQ-027 SHALL place the following in the shared timing package:
- a state enum with members RUN, HALT and STEP;
- constants NUM_TP=12 and NUM_SP=4.
REQ-028 SHALL place the MSTP edge detector in one sub-module named edge_rise (input level, output one-cycle pulse, synchronous reset).

Verification
REQ-029 Release reset with STOP=0 and run 96 cycles -> T_n walks T01..T12 twice, each Tk low for exactly 4 cycles; strobe order RT, WT, CT, TT in every Tk; MCYC_END pulses at cycles 47 and 95.
REQ-030 Assert STOP at T05 -> T12 completes; from cycle 48, MSTOPPED=1, T_n=12'hFFF and all strobes high; deassert STOP -> T01 RT_n=0 on the next cycle.
REQ-031 In HALT, give 3 MSTP rising edges spaced 60 cycles apart, with STOP held high -> exactly 3 memory cycles of 48 cycles each and 3 MCYC_END pulses; HALT is re-entered after each.
REQ-032 Assert GOJAM at T07 subphase 2 -> the next cycle shows T01 subphase 0; no MCYC_END for the truncated cycle.
REQ-033 Assert GOJAM in HALT with STOP=1 -> RUN at T01; HALT is re-entered after one 48-cycle memory cycle.
REQ-034 Assert SIM_RST during STEP at T09 with MSTP held high -> after reset the block is in RUN at T01 with no spurious step; an assertion checks one-hot T_n and mutually exclusive strobes on every cycle.
